add_pipe_nbit: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor; successor to the combinational ripple-carry `fa_nbit`.
- Splits the carry chain into CHUNK-bit segments, one register stage per segment, so WIDTH scales without growing the critical path.
- Adds a subtract mode, signed-overflow flag and a valid/ready handshake on both sides.
- Sits between operand producers and result consumers in datapaths that stream one operation per clock.

---
 rtl/add_pipe_nbit_if.sv | 27 ++
 rtl/add_pipe_nbit.sv | 92 +++++++++
 tb/tb_add_pipe_nbit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_nbit_if.sv
// Operand/result stream bundle for add_pipe_nbit.
// slave is the adder's view; master is the producer/consumer side.
interface add_pipe_nbit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/add_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor that resolves CHUNK bits of carry per stage.
// Latency is STAGES+1 register levels: operand capture, STAGES-1 chunk stages, output.
module add_pipe_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    add_pipe_nbit_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int PW     = STAGES * WIDTH;
    localparam int LAST   = STAGES - 1;

    // Slice k of sa_q/bw_q/cy_q/vld_q is the beat waiting to be added by stage k.
    // sa_q packs finished sum chunks at the top and unconsumed A chunks at the
    // bottom, so after the last stage the word is exactly the result.
    logic [PW-1:0]     sa_q;
    logic [PW-1:0]     bw_q;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] vld_q;

    logic [WIDTH-1:0]  s_q;
    logic              cout_q;
    logic              ovf_q;
    logic              out_valid_q;

    logic              en;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [PW-1:0]     nxt_sa;
    logic [PW-1:0]     nxt_b;
    logic [STAGES-1:0] nxt_c;
    logic              nxt_ovf;

    assign b_eff = bus.b ^ {WIDTH{bus.sub}};
    assign c0    = bus.cin ^ bus.sub;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rst || en;

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [CHUNK:0]   t;
        op_a    = '0;
        op_b    = '0;
        t       = '0;
        nxt_sa  = '0;
        nxt_b   = '0;
        nxt_c   = '0;
        nxt_ovf = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            op_a = sa_q[k*WIDTH +: WIDTH];
            op_b = bw_q[k*WIDTH +: WIDTH];
            t    = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, cy_q[k]};
            nxt_sa[k*WIDTH +: WIDTH] = (op_a >> CHUNK)
                                     | (WIDTH'(t[CHUNK-1:0]) << (WIDTH - CHUNK));
            nxt_b[k*WIDTH +: WIDTH]  = op_b >> CHUNK;
            nxt_c[k]                 = t[CHUNK];
            // Carry into the MSB is a^b^s at that bit; XOR with carry-out gives overflow.
            if (k == LAST) begin
                nxt_ovf = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ t[CHUNK-1] ^ t[CHUNK];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            sa_q        <= (nxt_sa << WIDTH) | PW'(bus.a);
            bw_q        <= (nxt_b << WIDTH) | PW'(b_eff);
            cy_q        <= (nxt_c << 1) | STAGES'(c0);
            vld_q       <= (vld_q << 1) | STAGES'(bus.in_valid);
            s_q         <= nxt_sa[LAST*WIDTH +: WIDTH];
            cout_q      <= nxt_c[LAST];
            ovf_q       <= nxt_ovf;
            out_valid_q <= vld_q[LAST];
        end
    end
endmodule

// File: tb/tb_add_pipe_nbit.sv
// Bench for add_pipe_nbit (WIDTH=16, CHUNK=4): directed vectors, random streaming,
// backpressure and mid-stream reset against an integer-arithmetic reference model.
module tb_add_pipe_nbit;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int LAT   = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   n_acc;
    logic [17:0] exp_q[$];

    add_pipe_nbit_if #(.WIDTH(WIDTH)) bus();

    add_pipe_nbit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns {ovf, cout, s} from plain signed/unsigned integer arithmetic.
    function automatic logic [17:0] ref_add(input logic [15:0] av, input logic [15:0] bv,
                                            input logic ci, input logic sb);
        int ua, ub, sa, sbv, r, rs;
        logic co, ov;
        logic [15:0] sum;
        ua  = int'(av);
        ub  = int'(bv);
        sa  = $signed(av);
        sbv = $signed(bv);
        if (sb) begin
            r  = ua - ub - int'(ci);
            rs = sa - sbv - int'(ci);
            co = (r >= 0);
        end else begin
            r  = ua + ub + int'(ci);
            rs = sa + sbv + int'(ci);
            co = (r > 65535);
        end
        sum = r[15:0];
        ov  = (rs > 32767) || (rs < -32768);
        return {ov, co, sum};
    endfunction

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input logic ordy);
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.cin       = ci;
        bus.sub       = sb;
        bus.out_ready = ordy;
    endtask

    task automatic drive_rand(input logic ordy);
        drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    // Observes the handshakes of the coming edge, then advances to the next negedge.
    task automatic step(output logic popped, output logic [17:0] got);
        #1;
        popped = bus.out_valid && bus.out_ready;
        got    = {bus.ovf, bus.cout, bus.s};
        if (bus.in_valid && bus.in_ready && !rst) begin
            exp_q.push_back(ref_add(bus.a, bus.b, bus.cin, bus.sub));
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic p;
        logic [17:0] g;
        rst = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end
        step(p, g);
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1;
        tests++;
        if ({bus.out_valid, bus.ovf, bus.cout, bus.s} !== 19'h0) begin
            fails++;
            $display("FAIL reset_outputs: got out_valid=%b ovf=%b cout=%b s=%h, expected all 0",
                     bus.out_valid, bus.ovf, bus.cout, bus.s);
        end
        for (int i = 0; i < 6; i++) begin
            step(p, g);
            #1;
            tests++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_beat[%0d]: out_valid=%b, expected 0", i, bus.out_valid);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
        logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
        logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] es [5] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFD};
        logic        ec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        eo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic p;
        logic [17:0] g;
        int lat;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1);
            #1;
            tests++;
            if (bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL vec%0d_in_ready: got %b, expected 1", i, bus.in_ready);
            end
            step(p, g);
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            for (lat = 0; lat < 10; lat++) begin
                #1;
                if (bus.out_valid === 1'b1) break;
                step(p, g);
            end
            tests++;
            if (lat != LAT) begin
                fails++;
                $display("FAIL vec%0d_latency: got %0d cycles, expected %0d", i, lat, LAT);
            end
            tests++;
            if ({bus.s, bus.cout, bus.ovf} !== {es[i], ec[i], eo[i]}) begin
                fails++;
                $display("FAIL vec%0d_result: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                         i, bus.s, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
            end
            step(p, g);
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic p;
        logic [17:0] g, e;
        int n_got, first, last;
        n_got = 0;
        first = -1;
        last  = -1;
        for (int cyc = 0; cyc < 34; cyc++) begin
            if (cyc < 20) drive_rand(1'b1);
            else drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            step(p, g);
            if (p) begin
                n_got++;
                if (first < 0) first = cyc;
                last = cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: unexpected result s=%h", g[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        fails++;
                        $display("FAIL stream[%0d]: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                                 n_got - 1, g[15:0], g[16], g[17], e[15:0], e[16], e[17]);
                    end
                end
            end
        end
        tests++;
        if (n_got != 20 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stream_count: got %0d results (%0d left), expected 20", n_got, exp_q.size());
        end
        tests++;
        if (last - first + 1 != 20) begin
            fails++;
            $display("FAIL stream_rate: results spread over %0d cycles, expected 20", last - first + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic p, stall;
        logic [17:0] g, e, held;
        int n_got, acc0;
        n_got = 0;
        acc0  = n_acc;
        held  = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            stall = (cyc >= 8) && (cyc < 13);
            if (cyc < 20) drive_rand(!stall);
            else drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (stall) begin
                #1;
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_in_ready[%0d]: got %b, expected 0", cyc, bus.in_ready);
                end
                if (cyc == 8) begin
                    held = {bus.ovf, bus.cout, bus.s};
                end else begin
                    tests++;
                    if ({bus.ovf, bus.cout, bus.s} !== held) begin
                        fails++;
                        $display("FAIL stall_hold[%0d]: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                                 cyc, bus.s, bus.cout, bus.ovf, held[15:0], held[16], held[17]);
                    end
                end
            end
            step(p, g);
            if (p) begin
                n_got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: unexpected result s=%h", g[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        fails++;
                        $display("FAIL bp[%0d]: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                                 n_got - 1, g[15:0], g[16], g[17], e[15:0], e[16], e[17]);
                    end
                end
            end
        end
        tests++;
        if (n_got != n_acc - acc0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bp_count: got %0d results, expected %0d", n_got, n_acc - acc0);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic p;
        logic [17:0] g, e;
        int n_got;
        n_got = 0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            step(p, g);
        end
        rst = 1'b1;
        drive_rand(1'b1);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_in_ready: got %b, expected 1", bus.in_ready);
        end
        step(p, g);
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.s !== 16'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got out_valid=%b s=%h, expected 0 and 0000",
                     bus.out_valid, bus.s);
        end
        exp_q.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 4) drive_rand(1'b1);
            else drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            step(p, g);
            if (p) begin
                n_got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rst_mid_extra: unexpected result s=%h", g[15:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        fails++;
                        $display("FAIL rst_mid[%0d]: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                                 n_got - 1, g[15:0], g[16], g[17], e[15:0], e[16], e[17]);
                    end
                end
            end
        end
        tests++;
        if (n_got != 4) begin
            fails++;
            $display("FAIL rst_mid_count: got %0d results, expected 4", n_got);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        n_acc = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
